// File: rtl/qspi_flash_responder.sv
// QSPI NOR-flash target answering Quad I/O Fast Read (0xEB) with continuous-read
// mode and the 0x66/0x99 reset sequence, served from a byte-wide synchronous memory.
module qspi_flash_responder #(
   parameter int unsigned MEM_AW       = 24,
   parameter int unsigned DUMMY_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sck,
   input  logic              ce_n,
   input  logic [3:0]        io_in,
   output logic [3:0]        io_out,
   output logic              io_oe,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [7:0]        mem_rdata,
   output logic              cont_mode,
   output logic              cmd_err
);

   typedef enum logic [2:0] {StIdle, StCmd, StAddr, StMode, StDummy, StData, StIgnore} state_e;

   localparam logic [7:0] DummyLast = 8'(DUMMY_CYCLES - 1);

   // [0],[1] synchronizer stages, [2] previous synchronized value for edge detect
   logic [2:0]        sck_sync_q, ce_sync_q;
   logic [3:0]        io_s1_q, io_s2_q;
   state_e            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [23:0]       shift_q, shift_d;
   logic [MEM_AW-1:0] addr_q, addr_d;
   logic              cont_q, cont_d, rst_en_q, rst_en_d;
   logic [7:0]        cur_q, cur_d, pre_q, pre_d;
   logic              nib_hi_q, nib_hi_d;
   logic [3:0]        io_out_q, io_out_d;
   logic              io_oe_q, io_oe_d;
   logic              rd_cur_q, rd_cur_d, rd_pre_q, rd_pre_d;
   logic              lat_cur_q, lat_pre_q;
   logic              cmd_err_q, cmd_err_d;

   logic        sck_rise, sck_fall, ce_rise, ce_fall;
   logic [23:0] shift_bit, shift_nib;

   assign sck_rise  = sck_sync_q[1] & ~sck_sync_q[2];
   assign sck_fall  = ~sck_sync_q[1] & sck_sync_q[2];
   assign ce_rise   = ce_sync_q[1] & ~ce_sync_q[2];
   assign ce_fall   = ~ce_sync_q[1] & ce_sync_q[2];
   assign shift_bit = {shift_q[22:0], io_s2_q[0]};
   assign shift_nib = {shift_q[19:0], io_s2_q};

   assign io_out    = io_out_q;
   assign io_oe     = io_oe_q;
   assign mem_addr  = addr_q;
   assign mem_rd    = rd_cur_q | rd_pre_q;
   assign cont_mode = cont_q;
   assign cmd_err   = cmd_err_q;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      shift_d   = shift_q;
      addr_d    = addr_q;
      cont_d    = cont_q;
      rst_en_d  = rst_en_q;
      cur_d     = lat_cur_q ? mem_rdata : cur_q;
      pre_d     = lat_pre_q ? mem_rdata : pre_q;
      nib_hi_d  = nib_hi_q;
      io_out_d  = io_out_q;
      io_oe_d   = io_oe_q;
      rd_cur_d  = 1'b0;
      rd_pre_d  = 1'b0;
      cmd_err_d = 1'b0;

      // ce_n rise has priority over any sck edge seen in the same cycle
      if (ce_rise) begin
         state_d  = StIdle;
         cnt_d    = '0;
         shift_d  = '0;
         io_oe_d  = 1'b0;
         io_out_d = '0;
         nib_hi_d = 1'b1;
      end else begin
         case (state_q)
            StIdle: begin
               if (ce_fall) begin
                  state_d = cont_q ? StAddr : StCmd;
                  cnt_d   = '0;
                  shift_d = '0;
               end
            end
            StCmd: begin
               if (sck_rise) begin
                  shift_d = shift_bit;
                  cnt_d   = cnt_q + 8'd1;
                  if (cnt_q == 8'd7) begin
                     cnt_d   = '0;
                     state_d = StIgnore;
                     if (shift_bit[7:0] == 8'hEB) begin
                        state_d  = StAddr;
                        rst_en_d = 1'b0;
                     end else if (shift_bit[7:0] == 8'h66) begin
                        rst_en_d = 1'b1;
                     end else if (shift_bit[7:0] == 8'h99 && rst_en_q) begin
                        cont_d   = 1'b0;
                        rst_en_d = 1'b0;
                     end else begin
                        cmd_err_d = 1'b1;
                        rst_en_d  = 1'b0;
                     end
                  end
               end
            end
            StAddr: begin
               if (sck_rise) begin
                  shift_d = shift_nib;
                  cnt_d   = cnt_q + 8'd1;
                  if (cnt_q == 8'd5) begin
                     addr_d  = MEM_AW'(shift_nib);
                     cnt_d   = '0;
                     state_d = StMode;
                  end
               end
            end
            StMode: begin
               if (sck_rise) begin
                  shift_d = shift_nib;
                  cnt_d   = cnt_q + 8'd1;
                  if (cnt_q == 8'd1) begin
                     cont_d   = (shift_nib[5:4] == 2'b10);
                     rd_cur_d = 1'b1;
                     cnt_d    = '0;
                     nib_hi_d = 1'b1;
                     state_d  = (DUMMY_CYCLES == 0) ? StData : StDummy;
                  end
               end
            end
            StDummy: begin
               if (sck_rise) begin
                  cnt_d = cnt_q + 8'd1;
                  if (cnt_q == DummyLast) begin
                     cnt_d   = '0;
                     state_d = StData;
                  end
               end
            end
            StData: begin
               if (sck_fall) begin
                  io_oe_d = 1'b1;
                  if (nib_hi_q) begin
                     // prefetch the next byte while the high nibble is on the bus
                     io_out_d = cur_q[7:4];
                     addr_d   = addr_q + MEM_AW'(1);
                     rd_pre_d = 1'b1;
                     nib_hi_d = 1'b0;
                  end else begin
                     io_out_d = cur_q[3:0];
                     cur_d    = pre_q;
                     nib_hi_d = 1'b1;
                  end
               end
            end
            StIgnore: ;
            default:  state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sck_sync_q <= 3'b000;
         ce_sync_q  <= 3'b111;
         io_s1_q    <= '0;
         io_s2_q    <= '0;
         state_q    <= StIdle;
         cnt_q      <= '0;
         shift_q    <= '0;
         addr_q     <= '0;
         cont_q     <= 1'b0;
         rst_en_q   <= 1'b0;
         cur_q      <= '0;
         pre_q      <= '0;
         nib_hi_q   <= 1'b1;
         io_out_q   <= '0;
         io_oe_q    <= 1'b0;
         rd_cur_q   <= 1'b0;
         rd_pre_q   <= 1'b0;
         lat_cur_q  <= 1'b0;
         lat_pre_q  <= 1'b0;
         cmd_err_q  <= 1'b0;
      end else begin
         sck_sync_q <= {sck_sync_q[1:0], sck};
         ce_sync_q  <= {ce_sync_q[1:0], ce_n};
         io_s1_q    <= io_in;
         io_s2_q    <= io_s1_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         addr_q     <= addr_d;
         cont_q     <= cont_d;
         rst_en_q   <= rst_en_d;
         cur_q      <= cur_d;
         pre_q      <= pre_d;
         nib_hi_q   <= nib_hi_d;
         io_out_q   <= io_out_d;
         io_oe_q    <= io_oe_d;
         rd_cur_q   <= rd_cur_d;
         rd_pre_q   <= rd_pre_d;
         lat_cur_q  <= rd_cur_q;
         lat_pre_q  <= rd_pre_q;
         cmd_err_q  <= cmd_err_d;
      end
   end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Randomized bench for qspi_flash_responder: drives QSPI frames as the initiator and
// compares returned nibbles, cont_mode and cmd_err against a protocol-level model.
module tb_qspi_flash_responder;

   localparam int HALF = 5;
   localparam int DUMMY = 4;

   logic        clk = 1'b0;
   logic        rst_n, sck, ce_n;
   logic [3:0]  io_in, io_out;
   logic        io_oe, mem_rd, cont_mode, cmd_err;
   logic [23:0] mem_addr;
   logic [7:0]  mem_rdata;

   int n_vec = 0, n_fail = 0;
   int err_cycles = 0, oe_cycles = 0;
   logic [31:0] seed;

   // protocol model state
   bit cont_exp = 1'b0, rst_en_exp = 1'b0;
   int err_exp = 0;
   logic [3:0] got_nib[$];
   logic       got_oe[$];
   int         pre_oe;

   qspi_flash_responder #(.MEM_AW(24), .DUMMY_CYCLES(DUMMY)) dut (
      .clk(clk), .rst_n(rst_n), .sck(sck), .ce_n(ce_n), .io_in(io_in),
      .io_out(io_out), .io_oe(io_oe), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_rdata(mem_rdata), .cont_mode(cont_mode), .cmd_err(cmd_err)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] mem_val(input logic [23:0] ad);
      logic [31:0] h;
      h = {8'h00, ad} * 32'h9E3779B1 + seed;
      return h[23:16] ^ h[7:0];
   endfunction

   function automatic logic [3:0] exp_nib(input logic [23:0] a, input int i);
      logic [7:0] b;
      b = mem_val(a + 24'(i / 2));
      return (i % 2 == 1) ? b[3:0] : b[7:4];
   endfunction

   always @(posedge clk) begin
      if (mem_rd === 1'b1) mem_rdata <= mem_val(mem_addr);
      if (cmd_err === 1'b1) err_cycles++;
      if (io_oe === 1'b1) oe_cycles++;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time exceeded, want finish before 5ms");
      $fatal(1);
   end

   task automatic pulse(input logic [3:0] d, output logic [3:0] o, output logic oe);
      io_in = d;
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      o   = io_out;
      oe  = io_oe;
      sck = 1'b0;
   endtask

   task automatic end_frame();
      ce_n = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic read_frame(input logic [23:0] a, input logic [7:0] m, input int nbytes,
                             input bit close);
      logic [3:0] o;
      logic       oe;
      logic [7:0] c;
      c = 8'hEB;
      got_nib.delete();
      got_oe.delete();
      pre_oe = 0;
      @(negedge clk);
      ce_n = 1'b0;
      repeat (2) @(negedge clk);
      if (!cont_exp) begin
         for (int i = 7; i >= 0; i--) begin
            pulse({3'($urandom), c[i]}, o, oe);
            pre_oe += int'(oe);
         end
         rst_en_exp = 1'b0;
      end
      for (int i = 5; i >= 0; i--) begin
         pulse(a[i*4 +: 4], o, oe);
         pre_oe += int'(oe);
      end
      for (int i = 1; i >= 0; i--) begin
         pulse(m[i*4 +: 4], o, oe);
         pre_oe += int'(oe);
      end
      for (int i = 0; i < DUMMY; i++) begin
         pulse(4'($urandom), o, oe);
         pre_oe += int'(oe);
      end
      cont_exp = (m[5:4] == 2'b10);
      for (int i = 0; i < 2 * nbytes; i++) begin
         pulse(4'($urandom), o, oe);
         got_nib.push_back(o);
         got_oe.push_back(oe);
      end
      if (close) end_frame();
   endtask

   task automatic send_cmd_frame(input logic [7:0] c);
      logic [3:0] o;
      logic       oe;
      @(negedge clk);
      ce_n = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 7; i >= 0; i--) pulse({3'($urandom), c[i]}, o, oe);
      for (int i = 0; i < 8; i++) pulse(4'($urandom), o, oe);
      end_frame();
      if (c == 8'h66) rst_en_exp = 1'b1;
      else if (c == 8'h99 && rst_en_exp) begin
         cont_exp   = 1'b0;
         rst_en_exp = 1'b0;
      end else begin
         err_exp++;
         rst_en_exp = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; sck = 1'b0; ce_n = 1'b1; io_in = '0;
      repeat (3) @(negedge clk);
      n_vec += 6;
      if (io_out !== 4'h0) begin n_fail++; $display("FAIL reset_io_out: got %h want 0", io_out); end
      if (io_oe !== 1'b0) begin n_fail++; $display("FAIL reset_io_oe: got %b want 0", io_oe); end
      if (mem_addr !== 24'h0) begin n_fail++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL reset_mem_rd: got %b want 0", mem_rd); end
      if (cont_mode !== 1'b0) begin n_fail++; $display("FAIL reset_cont_mode: got %b want 0", cont_mode); end
      if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_seq();
      send_cmd_frame(8'h66);
      send_cmd_frame(8'h99);
      n_vec += 2;
      if (err_cycles !== err_exp) begin n_fail++; $display("FAIL rstseq_err: got %0d want %0d", err_cycles, err_exp); end
      if (cont_mode !== cont_exp) begin n_fail++; $display("FAIL rstseq_cont: got %b want %b", cont_mode, cont_exp); end
   endtask

   task automatic test_read(input string name, input logic [23:0] a, input logic [7:0] m,
                            input int nbytes);
      read_frame(a, m, nbytes, 1'b1);
      for (int i = 0; i < 2 * nbytes; i++) begin
         n_vec++;
         if (got_nib[i] !== exp_nib(a, i) || got_oe[i] !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_data[%0d] @%h: got %h oe %b want %h oe 1", name, i, a, got_nib[i],
                     got_oe[i], exp_nib(a, i));
         end
      end
      n_vec += 3;
      if (pre_oe != 0) begin n_fail++; $display("FAIL %s_pre_oe: got %0d oe pulses want 0", name, pre_oe); end
      if (cont_mode !== cont_exp) begin n_fail++; $display("FAIL %s_cont: got %b want %b", name, cont_mode, cont_exp); end
      if (err_cycles !== err_exp) begin n_fail++; $display("FAIL %s_err: got %0d want %0d", name, err_cycles, err_exp); end
   endtask

   task automatic test_exit_cont();
      test_read("exit_cont", 24'($urandom), 8'hFF, 4);
      test_read("after_exit", 24'($urandom), 8'hFF, 16);
   endtask

   task automatic test_abort();
      logic [23:0] a;
      a = 24'($urandom);
      read_frame(a, 8'hA5, 5, 1'b0);
      ce_n = 1'b1;
      repeat (3) @(negedge clk);
      n_vec += 2;
      if (io_oe !== 1'b0) begin n_fail++; $display("FAIL abort_oe: got %b want 0", io_oe); end
      if (io_out !== 4'h0) begin n_fail++; $display("FAIL abort_io_out: got %h want 0", io_out); end
      for (int i = 0; i < 10; i++) begin
         n_vec++;
         if (got_nib[i] !== exp_nib(a, i)) begin
            n_fail++;
            $display("FAIL abort_data[%0d]: got %h want %h", i, got_nib[i], exp_nib(a, i));
         end
      end
      repeat (4) @(negedge clk);
      test_read("post_abort", 24'h000040, 8'hA5, 8);
   endtask

   task automatic test_bad_cmd();
      int oe0;
      if (cont_exp) test_read("drop_cont", 24'($urandom), 8'h00, 1);
      oe0 = oe_cycles;
      send_cmd_frame(8'h03);
      n_vec += 2;
      if (err_cycles !== err_exp) begin n_fail++; $display("FAIL bad03_err: got %0d want %0d", err_cycles, err_exp); end
      if (oe_cycles != oe0) begin n_fail++; $display("FAIL bad03_oe: got %0d oe cycles want 0", oe_cycles - oe0); end
      send_cmd_frame(8'h99);
      n_vec++;
      if (err_cycles !== err_exp) begin n_fail++; $display("FAIL bare99_err: got %0d want %0d", err_cycles, err_exp); end
   endtask

   task automatic test_rst_mid_data();
      read_frame(24'($urandom), 8'hA5, 3, 1'b0);
      rst_n = 1'b0;
      ce_n  = 1'b1;
      @(negedge clk);
      n_vec += 5;
      if (io_out !== 4'h0) begin n_fail++; $display("FAIL midrst_io_out: got %h want 0", io_out); end
      if (io_oe !== 1'b0) begin n_fail++; $display("FAIL midrst_io_oe: got %b want 0", io_oe); end
      if (mem_addr !== 24'h0) begin n_fail++; $display("FAIL midrst_addr: got %h want 0", mem_addr); end
      if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL midrst_rd: got %b want 0", mem_rd); end
      if (cont_mode !== 1'b0) begin n_fail++; $display("FAIL midrst_cont: got %b want 0", cont_mode); end
      cont_exp   = 1'b0;
      rst_en_exp = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      test_read("post_rst", 24'($urandom), 8'($urandom), 6);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 5; k++)
         test_read("b2b", 24'($urandom), 8'($urandom), int'($urandom_range(1, 8)));
   endtask

   initial begin
      seed = $urandom;
      mem_rdata = '0;
      test_reset();
      test_reset_seq();
      test_read("basic", 24'h000100, 8'hA5, 16);
      test_read("cont", 24'h000200, 8'hA5, 16);
      test_exit_cont();
      test_read("wrap", 24'hFFFFF8, 8'($urandom), 16);
      if (!cont_exp) test_read("arm_cont", 24'($urandom), 8'hA5, 2);
      test_abort();
      test_bad_cmd();
      test_rst_mid_data();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/qspi_flash_responder.md
# qspi_flash_responder

Synthesizable QSPI NOR-flash target that answers the Quad I/O Fast Read (0xEB) protocol, including continuous-read mode and the 0x66/0x99 reset sequence, from a byte-wide synchronous memory port. It is the far end of the flash-reader/cache initiator. It is used as an on-chip flash emulator (FPGA prototyping) and as the synthesizable flash stand-in for cache-controller regression. It oversamples the SPI pins with its own faster clock.

## Interface
- MEM_AW, 24: memory address width; the byte address wraps modulo 2^MEM_AW.
- DUMMY_CYCLES, 4: dummy sck cycles between the mode byte and the first data nibble.

Ports:
- clk  in  1  responder clock; sck high time and low time are each ≥ 4 clk periods.
- rst_n  in  1  reset: asynchronous, active-low.
- sck  in  1  SPI clock from initiator (mode 0).
- ce_n  in  1  chip enable, active-low.
- io_in  in  4  IO[3:0] driven by initiator.
- io_out  out  4  IO[3:0] driven by responder.
- io_oe  out  1  responder output enable.
- mem_addr  out  MEM_AW  byte address.
- mem_rd  out  1  read strobe, 1 clk.
- mem_rdata  in  8  read data, valid exactly 1 clk after mem_rd.
- cont_mode  out  1  continuous-read mode active.
- cmd_err  out  1  1-clk pulse on an unsupported command byte.

## Operation
- sck, ce_n and io_in each pass through a 2-flop synchronizer. Rise and fall edges are detected on synchronized sck only. io_in is sampled on a synchronized sck rise.
- States: IDLE, CMD, ADDR, MODE, DUMMY, DATA, IGNORE.
- IDLE, synchronized ce_n falls:
  - cont_mode=0 → CMD.
  - cont_mode=1 → ADDR.
- CMD: shift IO0 on 8 rises, MSB first.
  - 0xEB → ADDR; clears rst_en.
  - 0x66 → set rst_en; go to IGNORE.
  - 0x99 with rst_en=1 → clear cont_mode and rst_en; go to IGNORE.
  - Any other byte, or 0x99 with rst_en=0 → cmd_err pulse; clear rst_en; go to IGNORE.
- ADDR: 6 rises, one nibble each, MSB nibble first → addr register. Then go to MODE.
- MODE: 2 rises capture mode byte M.
  - On the 2nd rise: cont_mode <= (M[5:4]==2'b10); issue mem_rd at addr.
  - Latch mem_rdata into the byte register the next clk.
  - Go to DUMMY.
- DUMMY: count DUMMY_CYCLES rises, then go to DATA.
- DATA: on each sck fall, starting with the fall after the last dummy rise:
  - Drive the next nibble, high nibble first; io_oe=1.
  - When the high nibble is driven: addr <= addr+1 (wraps), issue mem_rd for the next byte, and latch it into the prefetch register one clk later.
  - When the low nibble is driven: the prefetch register becomes the current byte.
  - DATA streams indefinitely until ce_n rises.
- Synchronized ce_n rise in any state → IDLE; io_oe=0; io_out=0; partial shift/counters cleared. cont_mode and rst_en are retained.
- IGNORE: io_oe=0; wait for ce_n rise.
- io_oe is 0 in every state except DATA.

## Timing
- Reset values: io_out=0, io_oe=0, mem_addr=0, mem_rd=0, cont_mode=0, cmd_err=0, state IDLE, rst_en=0.
- Edge detect latency: 3 clk from pin transition to action (2 sync + 1 register).
- Output nibble changes 3 clk after the physical sck fall. This is stable well before the initiator samples at the next fall.
- First byte: mem_rd occurs at the 2nd MODE rise + 1 clk. Data is needed at the first DATA fall, ≥ DUMMY_CYCLES sck later, so there is no stall.
- Next byte: fetched during the high-nibble half-period, ≥ 4 clk before it is needed.
- Simultaneous ce_n rise and sck edge in the same clk: ce_n wins; the edge is dropped.
- rst_n asserted mid-transaction: immediate return to reset values. The next ce_n low is decoded as a fresh command (cont_mode=0).
- Address wrap: 0x(2^MEM_AW − 1) + 1 = 0; no error.
- Initiator bytes after a 16-byte line: the responder keeps streaming; only the ce_n rise ends the burst.

## Test plan
- Send 0x66 frame, then 0x99 frame, then EB at addr 0x000100 with M=0xA5 and 16 bytes → bytes equal mem[0x100..0x10F], high nibble first; cont_mode=1; cmd_err never pulses.
- Continuous mode active, ce_n low, send address 0x000200 + M=0xA5 with no command → mem[0x200..0x20F] returned; io_oe low during address, mode and dummy.
- EB with M=0xFF → data correct, cont_mode=0 afterwards. Next frame's first 8 bits are decoded as a command (0xEB accepted).
- EB at 0xFFFFF8, 16 bytes → mem[0xFFFFF8..0xFFFFFF], then mem[0x000000..0x000007].
- Raise ce_n after 5 data bytes → io_oe=0 within 3 clk, state IDLE. The following continuous-mode read at 0x000040 returns correct data.
- Command 0x03 → cmd_err single pulse, io_oe stays 0 for the whole frame. Separately, rst_n pulse mid-DATA → all outputs at reset values, cont_mode=0.
